// File: rtl/cr_axi4s_slv_pkt.sv
// AXI4-Stream slave ingress buffer: input register, FWFT register-array FIFO, credit-based tready,
// optional store-and-forward release (PKT_MODE=1). Statistics counters built only with CR_AXI4S_SLV_STATS_EN.
module cr_axi4s_slv_pkt #(
   parameter int DATA_W     = 64,
   parameter int USER_W     = 8,
   parameter int DEPTH      = 16,
   parameter int AFULL_VAL  = 1,
   parameter int AEMPTY_VAL = 1,
   parameter int PKT_MODE   = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          s_tvalid,
   output logic                          s_tready,
   input  logic [DATA_W-1:0]             s_tdata,
   input  logic [USER_W-1:0]             s_tuser,
   input  logic                          s_tlast,
   input  logic                          rd,
   output logic [DATA_W+USER_W:0]        rdata,
   output logic                          empty,
   output logic                          aempty,
   output logic [$clog2(DEPTH):0]        pkt_avail,
   output logic                          err_ovsz,
   output logic                          err_urun,
   output logic [31:0]                   stat_beats,
   output logic [31:0]                   stat_pkts,
   input  logic                          stat_clr
);

   localparam int ENT_W = DATA_W + USER_W + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]   USED_MAX   = (CNT_W+1)'(DEPTH - AFULL_VAL);
   localparam logic [CNT_W-1:0] AEMPTY_LIM = CNT_W'(AEMPTY_VAL);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
   localparam logic             PKT_EN     = (PKT_MODE != 0);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] in_q, in_d;
   logic             wen_q, wen_d;
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d, pkt_q, pkt_d;
   logic             rdy_q;
   logic             bypass_q, bypass_d;
   logic             err_ovsz_q, err_ovsz_d;
   logic             err_urun_q, err_urun_d;
   logic [CNT_W:0]   used;
   logic             accept, pop, head_last, empty_int, ovsz_set;

   // Handshake: a beat transfers on the rising edge where s_tvalid and s_tready are both high;
   // s_tready depends only on registered state, so it never combinationally follows s_tvalid.
   assign used      = {1'b0, count_q} + {{CNT_W{1'b0}}, wen_q};
   assign s_tready  = rdy_q & (used <= USED_MAX);
   assign accept    = s_tvalid & s_tready;

   assign rdata     = mem_q[rptr_q];
   assign head_last = rdata[ENT_W-1];
   // In packet mode the head is held back until a whole packet is stored, unless an
   // oversize packet has filled the FIFO and must stream out to avoid deadlock.
   assign empty_int = (count_q == '0) | (PKT_EN & (pkt_q == '0) & ~bypass_q);
   assign pop       = rd & ~empty_int;
   assign ovsz_set  = PKT_EN & (count_q == FULL_CNT) & (pkt_q == '0);

   assign empty     = empty_int;
   assign aempty    = (count_q <= AEMPTY_LIM);
   assign pkt_avail = pkt_q;
   assign err_ovsz  = err_ovsz_q;
   assign err_urun  = err_urun_q;

   always_comb begin
      in_d       = in_q;
      wen_d      = accept;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      pkt_d      = pkt_q;
      bypass_d   = bypass_q;
      err_ovsz_d = err_ovsz_q | ovsz_set;
      err_urun_d = err_urun_q | (rd & empty_int);
      if (accept) begin
         in_d = {s_tlast, s_tuser, s_tdata};
      end
      if (wen_q) begin
         wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      case ({wen_q, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      case ({wen_q & in_q[ENT_W-1], pop & head_last})
         2'b10:   pkt_d = pkt_q + CNT_W'(1);
         2'b01:   pkt_d = pkt_q - CNT_W'(1);
         default: pkt_d = pkt_q;
      endcase
      if (pop & head_last) begin
         bypass_d = 1'b0;
      end
      if (ovsz_set) begin
         bypass_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_q       <= '0;
         wen_q      <= 1'b0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         pkt_q      <= '0;
         rdy_q      <= 1'b0;
         bypass_q   <= 1'b0;
         err_ovsz_q <= 1'b0;
         err_urun_q <= 1'b0;
      end else begin
         in_q       <= in_d;
         wen_q      <= wen_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         pkt_q      <= pkt_d;
         rdy_q      <= 1'b1;
         bypass_q   <= bypass_d;
         err_ovsz_q <= err_ovsz_d;
         err_urun_q <= err_urun_d;
      end
   end

   // Storage needs no reset: count/pointers define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (wen_q) begin
         mem_q[wptr_q] <= in_q;
      end
   end

`ifdef CR_AXI4S_SLV_STATS_EN
   logic [31:0] stat_beats_q, stat_beats_d, stat_pkts_q, stat_pkts_d;

   always_comb begin
      stat_beats_d = stat_beats_q;
      stat_pkts_d  = stat_pkts_q;
      if (stat_clr) begin
         stat_beats_d = '0;
         stat_pkts_d  = '0;
      end else begin
         if (accept && (stat_beats_q != 32'hFFFF_FFFF)) begin
            stat_beats_d = stat_beats_q + 32'd1;
         end
         if (accept && s_tlast && (stat_pkts_q != 32'hFFFF_FFFF)) begin
            stat_pkts_d = stat_pkts_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_beats_q <= '0;
         stat_pkts_q  <= '0;
      end else begin
         stat_beats_q <= stat_beats_d;
         stat_pkts_q  <= stat_pkts_d;
      end
   end

   assign stat_beats = stat_beats_q;
   assign stat_pkts  = stat_pkts_q;
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_beats      = '0;
   assign stat_pkts       = '0;
`endif

endmodule

// File: tb/tb_cr_axi4s_slv_pkt.sv
// Directed bench for cr_axi4s_slv_pkt: one cut-through instance (a_*) and one packet-mode instance (b_*).
module tb_cr_axi4s_slv_pkt;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CR_AXI4S_SLV_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        a_rst_n, a_tvalid, a_tready, a_tlast, a_rd, a_empty, a_aempty, a_ovsz, a_urun, a_sclr;
   logic [15:0] a_tdata;
   logic [3:0]  a_tuser;
   logic [20:0] a_rdata;
   logic [4:0]  a_pkt;
   logic [31:0] a_sbeats, a_spkts;

   logic        b_rst_n, b_tvalid, b_tready, b_tlast, b_rd, b_empty, b_aempty, b_ovsz, b_urun, b_sclr;
   logic [15:0] b_tdata;
   logic [3:0]  b_tuser;
   logic [20:0] b_rdata;
   logic [4:0]  b_pkt;
   logic [31:0] b_sbeats, b_spkts;

   int n_vec = 0;
   int n_err = 0;
   logic [20:0] exp_a[$];
   logic [20:0] exp_b[$];
   logic [15:0] a_d;

   cr_axi4s_slv_pkt #(.DATA_W(16), .USER_W(4), .DEPTH(16), .AFULL_VAL(1), .AEMPTY_VAL(1), .PKT_MODE(0)) u_a (
      .clk(clk), .rst_n(a_rst_n), .s_tvalid(a_tvalid), .s_tready(a_tready), .s_tdata(a_tdata),
      .s_tuser(a_tuser), .s_tlast(a_tlast), .rd(a_rd), .rdata(a_rdata), .empty(a_empty),
      .aempty(a_aempty), .pkt_avail(a_pkt), .err_ovsz(a_ovsz), .err_urun(a_urun),
      .stat_beats(a_sbeats), .stat_pkts(a_spkts), .stat_clr(a_sclr));

   cr_axi4s_slv_pkt #(.DATA_W(16), .USER_W(4), .DEPTH(16), .AFULL_VAL(1), .AEMPTY_VAL(1), .PKT_MODE(1)) u_b (
      .clk(clk), .rst_n(b_rst_n), .s_tvalid(b_tvalid), .s_tready(b_tready), .s_tdata(b_tdata),
      .s_tuser(b_tuser), .s_tlast(b_tlast), .rd(b_rd), .rdata(b_rdata), .empty(b_empty),
      .aempty(b_aempty), .pkt_avail(b_pkt), .err_ovsz(b_ovsz), .err_urun(b_urun),
      .stat_beats(b_sbeats), .stat_pkts(b_spkts), .stat_clr(b_sclr));

   function automatic logic [20:0] mk(input logic [15:0] d, input logic l);
      mk = {l, d[3:0] ^ 4'hA, d};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic [15:0] d, input logic l);
      a_tdata = d;
      a_tuser = d[3:0] ^ 4'hA;
      a_tlast = l;
   endtask

   task automatic drv_b(input logic [15:0] d, input logic l);
      b_tdata = d;
      b_tuser = d[3:0] ^ 4'hA;
      b_tlast = l;
   endtask

   task automatic test_reset;
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_tvalid = 1'b0; b_tvalid = 1'b0; a_rd = 1'b0; b_rd = 1'b0; a_sclr = 1'b0; b_sclr = 1'b0;
      drv_a(16'h0, 1'b0); drv_b(16'h0, 1'b0);
      tick; tick;
      n_vec++; if (a_tready !== 1'b0) begin n_err++; $display("FAIL rst_a_tready: got %b exp 0", a_tready); end
      n_vec++; if (b_tready !== 1'b0) begin n_err++; $display("FAIL rst_b_tready: got %b exp 0", b_tready); end
      n_vec++; if ({a_empty, a_aempty} !== 2'b11) begin n_err++; $display("FAIL rst_a_empty_aempty: got %b exp 11", {a_empty, a_aempty}); end
      n_vec++; if ({b_empty, b_aempty} !== 2'b11) begin n_err++; $display("FAIL rst_b_empty_aempty: got %b exp 11", {b_empty, b_aempty}); end
      n_vec++; if ({a_pkt, a_ovsz, a_urun} !== 7'd0) begin n_err++; $display("FAIL rst_a_pkt_err: got %b exp 0", {a_pkt, a_ovsz, a_urun}); end
      n_vec++; if ({b_pkt, b_ovsz, b_urun} !== 7'd0) begin n_err++; $display("FAIL rst_b_pkt_err: got %b exp 0", {b_pkt, b_ovsz, b_urun}); end
      n_vec++; if ({a_sbeats, a_spkts} !== 64'd0) begin n_err++; $display("FAIL rst_a_stats: got %h exp 0", {a_sbeats, a_spkts}); end
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      tick;
      n_vec++; if ({a_tready, b_tready} !== 2'b11) begin n_err++; $display("FAIL rst_exit_tready: got %b exp 11", {a_tready, b_tready}); end
      n_vec++; if ({a_empty, b_empty} !== 2'b11) begin n_err++; $display("FAIL rst_exit_empty: got %b exp 11", {a_empty, b_empty}); end
   endtask

   // Continuous valid into an idle FIFO with no reads: exactly DEPTH beats fit.
   task automatic test_fill;
      int   acc_n;
      logic acc;
      acc_n = 0; a_d = 16'h0; drv_a(a_d, 1'b0); a_tvalid = 1'b1;
      for (int c = 0; c < 24; c++) begin
         acc = a_tready;
         if (acc) exp_a.push_back(mk(a_d, 1'b0));
         tick;
         if (acc) begin acc_n++; a_d = a_d + 16'd1; drv_a(a_d, 1'b0); end
         if (c == 0) begin
            n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL fill_empty_c1: got %b exp 1", a_empty); end
         end
         if (c == 1) begin
            n_vec++; if (a_empty !== 1'b0) begin n_err++; $display("FAIL fill_empty_c2: got %b exp 0", a_empty); end
            n_vec++; if (a_rdata !== mk(16'h0, 1'b0)) begin n_err++; $display("FAIL fill_first_rdata: got %h exp %h", a_rdata, mk(16'h0, 1'b0)); end
            n_vec++; if (a_aempty !== 1'b1) begin n_err++; $display("FAIL fill_aempty_cnt1: got %b exp 1", a_aempty); end
         end
         if (c == 2) begin
            n_vec++; if (a_aempty !== 1'b0) begin n_err++; $display("FAIL fill_aempty_cnt2: got %b exp 0", a_aempty); end
         end
      end
      a_tvalid = 1'b0;
      n_vec++; if (acc_n !== 16) begin n_err++; $display("FAIL fill_accepts: got %0d exp 16", acc_n); end
      n_vec++; if (a_tready !== 1'b0) begin n_err++; $display("FAIL fill_tready_full: got %b exp 0", a_tready); end
      n_vec++; if (a_pkt !== 5'd0) begin n_err++; $display("FAIL fill_pkt_avail: got %0d exp 0", a_pkt); end
   endtask

   // Full FIFO with read and valid both high: steady one beat per cycle, order preserved.
   task automatic test_back_to_back;
      int   pops, accs, drained;
      logic acc;
      pops = 0; accs = 0; drained = 0;
      a_tvalid = 1'b1; a_rd = 1'b1;
      for (int c = 0; c < 8; c++) begin
         acc = a_tready;
         if (!a_empty) begin
            n_vec++;
            if (exp_a.size() == 0 || a_rdata !== exp_a[0]) begin n_err++; $display("FAIL b2b_rdata: got %h exp %h", a_rdata, (exp_a.size() == 0) ? 21'h0 : exp_a[0]); end
            if (exp_a.size() != 0) void'(exp_a.pop_front());
            pops++;
         end
         if (acc) exp_a.push_back(mk(a_d, 1'b0));
         tick;
         if (acc) begin accs++; a_d = a_d + 16'd1; drv_a(a_d, 1'b0); end
      end
      a_tvalid = 1'b0;
      n_vec++; if (pops !== 8) begin n_err++; $display("FAIL b2b_pops: got %0d exp 8", pops); end
      n_vec++; if (accs !== 7) begin n_err++; $display("FAIL b2b_accepts: got %0d exp 7", accs); end
      for (int c = 0; c < 64 && (exp_a.size() != 0 || !a_empty); c++) begin
         a_rd = !a_empty;
         if (a_rd) begin
            n_vec++;
            if (exp_a.size() == 0 || a_rdata !== exp_a[0]) begin n_err++; $display("FAIL drain_rdata: got %h exp %h", a_rdata, (exp_a.size() == 0) ? 21'h0 : exp_a[0]); end
            if (exp_a.size() != 0) void'(exp_a.pop_front());
            drained++;
         end
         tick;
      end
      a_rd = 1'b0;
      n_vec++; if (drained !== 15) begin n_err++; $display("FAIL drain_count: got %0d exp 15", drained); end
      n_vec++; if (a_empty !== 1'b1 || exp_a.size() != 0) begin n_err++; $display("FAIL drain_empty: got %b left %0d exp 1 left 0", a_empty, exp_a.size()); end
      n_vec++; if (a_urun !== 1'b0) begin n_err++; $display("FAIL drain_no_urun: got %b exp 0", a_urun); end
   endtask

   task automatic test_underrun_reset;
      a_rd = 1'b1; tick; a_rd = 1'b0;
      n_vec++; if ({a_urun, a_empty} !== 2'b11) begin n_err++; $display("FAIL urun_set: got %b exp 11", {a_urun, a_empty}); end
      tick;
      n_vec++; if (a_urun !== 1'b1) begin n_err++; $display("FAIL urun_sticky: got %b exp 1", a_urun); end
      drv_a(16'h5A5A, 1'b1); a_tvalid = 1'b1; tick; a_tvalid = 1'b0; tick;
      n_vec++; if (a_rdata !== mk(16'h5A5A, 1'b1) || a_empty !== 1'b0) begin n_err++; $display("FAIL urun_rptr_kept: got %h/%b exp %h/0", a_rdata, a_empty, mk(16'h5A5A, 1'b1)); end
      n_vec++; if (a_pkt !== 5'd1) begin n_err++; $display("FAIL urun_pkt_avail: got %0d exp 1", a_pkt); end
      a_rd = 1'b1; tick; a_rd = 1'b0;
      n_vec++; if ({a_empty, a_pkt} !== 6'b1_00000) begin n_err++; $display("FAIL urun_pop: got %b exp 100000", {a_empty, a_pkt}); end
      a_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin drv_a(16'h0700 + 16'(i), 1'b0); tick; end
      a_rst_n = 1'b0; tick;
      n_vec++; if ({a_empty, a_aempty, a_tready, a_urun} !== 4'b1100) begin n_err++; $display("FAIL midrst_state: got %b exp 1100", {a_empty, a_aempty, a_tready, a_urun}); end
      a_rst_n = 1'b1; a_tvalid = 1'b0; tick;
      n_vec++; if ({a_tready, a_empty} !== 2'b11) begin n_err++; $display("FAIL midrst_exit: got %b exp 11", {a_tready, a_empty}); end
      tick;
      n_vec++; if ({a_empty, a_pkt} !== 6'b1_00000) begin n_err++; $display("FAIL midrst_discard: got %b exp 100000", {a_empty, a_pkt}); end
      exp_a.delete();
   endtask

   // Packet mode: gapped 3-beat packet is released only once its tlast is stored.
   task automatic test_pkt_release;
      for (int k = 0; k < 3; k++) begin
         drv_b(16'd100 + 16'(k), k == 2); b_tvalid = 1'b1;
         exp_b.push_back(mk(16'd100 + 16'(k), k == 2));
         n_vec++; if (b_tready !== 1'b1) begin n_err++; $display("FAIL pkt_tready: got %b exp 1", b_tready); end
         tick; b_tvalid = 1'b0;
         n_vec++; if ({b_empty, b_pkt} !== 6'b1_00000) begin n_err++; $display("FAIL pkt_hold_a k%0d: got %b exp 100000", k, {b_empty, b_pkt}); end
         tick;
         n_vec++;
         if (k < 2) begin
            if ({b_empty, b_pkt} !== 6'b1_00000) begin n_err++; $display("FAIL pkt_hold_b k%0d: got %b exp 100000", k, {b_empty, b_pkt}); end
         end else begin
            if ({b_empty, b_pkt} !== 6'b0_00001) begin n_err++; $display("FAIL pkt_release: got %b exp 000001", {b_empty, b_pkt}); end
         end
         tick;
      end
      n_vec++; if (b_aempty !== 1'b0) begin n_err++; $display("FAIL pkt_aempty: got %b exp 0", b_aempty); end
      b_rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_vec++; if ({b_empty, b_pkt} !== 6'b0_00001) begin n_err++; $display("FAIL pkt_pop_state i%0d: got %b exp 000001", i, {b_empty, b_pkt}); end
         n_vec++; if (b_rdata !== exp_b[0]) begin n_err++; $display("FAIL pkt_rdata i%0d: got %h exp %h", i, b_rdata, exp_b[0]); end
         void'(exp_b.pop_front());
         tick;
      end
      b_rd = 1'b0;
      n_vec++; if ({b_empty, b_aempty, b_pkt} !== 7'b11_00000) begin n_err++; $display("FAIL pkt_done: got %b exp 1100000", {b_empty, b_aempty, b_pkt}); end
   endtask

   // Packet mode: a 20-beat packet overflows DEPTH, forces bypass, streams out in order.
   task automatic test_oversize;
      int   idx, pops, ovsz_c, acc16_c;
      logic acc, pop;
      idx = 0; pops = 0; ovsz_c = -10; acc16_c = -10;
      drv_b(16'd200, 1'b0); b_tvalid = 1'b1;
      for (int c = 0; c < 120; c++) begin
         acc = b_tvalid & b_tready;
         pop = b_rd & !b_empty;
         if (pop) begin
            n_vec++;
            if (exp_b.size() == 0 || b_rdata !== exp_b[0]) begin n_err++; $display("FAIL ovsz_rdata: got %h exp %h", b_rdata, (exp_b.size() == 0) ? 21'h0 : exp_b[0]); end
            if (exp_b.size() != 0) void'(exp_b.pop_front());
            pops++;
         end
         if (acc) begin
            exp_b.push_back(mk(16'd200 + 16'(idx), idx == 19));
            if (idx == 15) acc16_c = c;
         end
         tick;
         if (acc) begin
            idx++;
            if (idx > 20) b_tvalid = 1'b0;
            else drv_b(16'd200 + 16'(idx), idx == 19);
         end
         if (c == acc16_c + 1) begin
            n_vec++; if ({b_empty, b_ovsz} !== 2'b10) begin n_err++; $display("FAIL ovsz_full_hold: got %b exp 10", {b_empty, b_ovsz}); end
         end
         if (b_ovsz && ovsz_c < 0) begin
            ovsz_c = c;
            n_vec++; if (pops !== 0 || b_empty !== 1'b0) begin n_err++; $display("FAIL ovsz_bypass_open: pops %0d empty %b exp 0 0", pops, b_empty); end
         end
         b_rd = (ovsz_c >= 0) & !b_empty;
         if (idx > 20 && pops == 20) break;
      end
      b_rd = 1'b0; b_tvalid = 1'b0;
      tick; tick;
      n_vec++; if ((ovsz_c - acc16_c) !== 2) begin n_err++; $display("FAIL ovsz_timing: got %0d exp 2", ovsz_c - acc16_c); end
      n_vec++; if (pops !== 20) begin n_err++; $display("FAIL ovsz_delivered: got %0d exp 20", pops); end
      n_vec++; if (exp_b.size() != 1) begin n_err++; $display("FAIL ovsz_leftover: got %0d exp 1", exp_b.size()); end
      n_vec++; if ({b_empty, b_aempty, b_pkt} !== 7'b11_00000) begin n_err++; $display("FAIL ovsz_bypass_clear: got %b exp 1100000", {b_empty, b_aempty, b_pkt}); end
      n_vec++; if ({b_ovsz, b_urun} !== 2'b10) begin n_err++; $display("FAIL ovsz_flags: got %b exp 10", {b_ovsz, b_urun}); end
   endtask

   task automatic test_stats;
      int   k;
      logic acc;
      k = 0; drv_a(16'd300, 1'b0); a_tvalid = 1'b1;
      for (int c = 0; c < 200 && k < 20; c++) begin
         acc = a_tready;
         tick;
         if (acc) begin
            k++;
            if (k < 20) drv_a(16'd300 + 16'(k), (k % 4) == 3);
         end
         a_rd = !a_empty;
      end
      a_tvalid = 1'b0;
      n_vec++; if (k !== 20) begin n_err++; $display("FAIL stats_accepts: got %0d exp 20", k); end
      n_vec++; if (a_sbeats !== (STATS ? 32'd20 : 32'd0)) begin n_err++; $display("FAIL stats_beats: got %0d exp %0d", a_sbeats, STATS ? 20 : 0); end
      n_vec++; if (a_spkts !== (STATS ? 32'd5 : 32'd0)) begin n_err++; $display("FAIL stats_pkts: got %0d exp %0d", a_spkts, STATS ? 5 : 0); end
      drv_a(16'd400, 1'b1); a_tvalid = 1'b1;
      n_vec++; if (a_tready !== 1'b1) begin n_err++; $display("FAIL stats_clr_tready: got %b exp 1", a_tready); end
      a_sclr = 1'b1; tick; a_sclr = 1'b0; a_tvalid = 1'b0;
      a_rd = !a_empty;
      n_vec++; if ({a_sbeats, a_spkts} !== 64'd0) begin n_err++; $display("FAIL stats_clr_wins: got %h exp 0", {a_sbeats, a_spkts}); end
      drv_a(16'd401, 1'b1); a_tvalid = 1'b1; tick; a_tvalid = 1'b0;
      n_vec++; if ({a_sbeats, a_spkts} !== (STATS ? {32'd1, 32'd1} : 64'd0)) begin n_err++; $display("FAIL stats_after_clr: got %h exp %0d each", {a_sbeats, a_spkts}, STATS ? 1 : 0); end
      for (int c = 0; c < 64 && !(a_empty && !a_rd); c++) begin
         a_rd = !a_empty;
         tick;
      end
      a_rd = 1'b0;
      n_vec++; if ({a_empty, a_urun} !== 2'b10) begin n_err++; $display("FAIL stats_drain: got %b exp 10", {a_empty, a_urun}); end
   endtask

   initial begin
      test_reset;
      test_fill;
      test_back_to_back;
      test_underrun_reset;
      test_pkt_release;
      test_oversize;
      test_stats;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
